// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU sequencer: state encodings and the width of
// the memory wait counter.
package cpu_sequencer_pkg;

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- multi-cycle instruction sequencer.
// Walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// and stops in HALTED until reset. Every memory request is bounded by
// MEM_TIMEOUT wait cycles. If no ack arrives in that time, a bus exception
// is raised and the PC is advanced.
//
// Ports
//   clk_cpu, reset          clock; asynchronous active-high reset
//   imem_req / imem_ack     instruction fetch handshake, inst_in = fetched word
//   inst                    instruction register
//   is_load/is_store/halt   decoded flags for the current inst
//   dmem_req/dmem_we/dmem_ack  data memory handshake
//   pc_en, rf_we, bus_excp  one-cycle strobes
//   state                   current state encoding (debug)
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk_cpu,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] inst_in,
  output logic [31:0] inst,
  input  logic        is_load,
  input  logic        is_store,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        halt,
  output logic        pc_en,
  output logic        rf_we,
  output logic        bus_excp,
  output logic [2:0]  state
);

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

  state_t             r_state;
  logic [31:0]        r_inst;
  logic [WAIT_W-1:0]  r_wait;

  logic w_req_i;
  logic w_req_d;
  logic w_tmo;
  logic w_wb;

  // The timeout strobe must react to an ack in the same cycle, so that a
  // late ack still wins. For that reason the strobes are decoded from the
  // registered state and the wait counter. They are not registered again.
  // imem_req is gated by reset so that it stays low while reset is applied.
  always_comb begin
    w_req_i  = (r_state == ST_FETCH) && !reset;
    w_req_d  = (r_state == ST_MEM);
    w_wb     = (r_state == ST_WB);
    w_tmo    = (r_wait == TMO) &&
               ((w_req_i && !imem_ack) || (w_req_d && !dmem_ack));
    imem_req = w_req_i;
    dmem_req = w_req_d;
    dmem_we  = w_req_d && is_store;
    pc_en    = w_wb || w_tmo;
    rf_we    = w_wb && !is_store;
    bus_excp = w_tmo;
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_inst  <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            r_inst  <= inst_in;
            r_state <= ST_DECODE;
          end else if (w_tmo) begin
            r_wait  <= '0;
          end else begin
            r_wait  <= r_wait + WAIT_W'(1);
          end
        end
        ST_DECODE: r_state <= ST_EXEC;
        ST_EXEC: begin
          r_wait  <= '0;
          r_state <= (is_load || is_store) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (dmem_ack) begin
            r_state <= ST_WB;
          end else if (w_tmo) begin
            r_wait  <= '0;
            r_state <= ST_FETCH;
          end else begin
            r_wait  <= r_wait + WAIT_W'(1);
          end
        end
        ST_WB: begin
          r_wait  <= '0;
          r_state <= halt ? ST_HALTED : ST_FETCH;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default: begin
          r_wait  <= '0;
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign inst  = r_inst;
  assign state = r_state;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max wait cycles per memory request before a bus-timeout exception (legal 1..255).
REQ-002 SHALL have port clk_cpu  input  1  CPU clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request, held until acknowledged.
REQ-005 SHALL have port imem_ack  input  1  fetch data valid on inst_in this cycle.
REQ-006 SHALL have port inst_in  input  32  fetched instruction word.
REQ-007 SHALL have port inst  output  32  instruction register driving decode, ALU and program counter.
REQ-008 SHALL have port is_load / is_store  input  1 each  decoded memory-op flags for the current inst.
REQ-009 SHALL have port dmem_req  output  1  data memory request; dmem_we  output  1  write qualifier.
REQ-010 SHALL have port dmem_ack  input  1  data memory completion.
REQ-011 SHALL have port halt  input  1  decoded halt instruction.
REQ-012 SHALL have port pc_en  output  1  one-cycle strobe gating the program counter clock enable.
REQ-013 SHALL have port rf_we  output  1  one-cycle register-file write strobe.
REQ-014 SHALL have port bus_excp  output  1  one-cycle timeout exception strobe, ORed into the exception path of the control word.
REQ-015 SHALL have port state  output  3  current state encoding, for debug.

Function
REQ-016 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5; codes 6-7 go to FETCH.
REQ-017 FETCH: imem_req=1; on imem_ack, inst<=inst_in and next state DECODE.
REQ-018 DECODE: one cycle, then EXEC.
REQ-019 EXEC: one cycle; next MEM if is_load|is_store, else WB.
REQ-020 MEM: dmem_req=1, dmem_we=is_store; on dmem_ack, next WB.
REQ-021 WB: one cycle; pc_en=1; rf_we=~is_store; next HALTED if halt, else FETCH.
REQ-022 HALTED: all strobes 0; leaves only via reset.
REQ-023 SHALL run an 8-bit wait counter, cleared on entry to FETCH or MEM and incremented each unacknowledged cycle there.
REQ-024 When the counter equals MEM_TIMEOUT without ack: bus_excp=1 and pc_en=1 for that cycle, rf_we=0, inst unchanged, next FETCH.
REQ-025 Ack in the same cycle as timeout SHALL win: no bus_excp, normal transition.
REQ-026 Ack while not requesting SHALL be ignored.
REQ-027 Non-memory instruction latency SHALL be 4 cycles with zero-wait ack (FETCH, DECODE, EXEC, WB); memory instructions 5.
REQ-028 pc_en, rf_we and bus_excp SHALL be mutually consistent: at most one pc_en per instruction.

Reset
REQ-029 On reset: state=FETCH, inst=0, counter=0, all outputs 0 except imem_req, which is 1 from the first cycle after reset deasserts.
REQ-030 Reset mid-request SHALL abort the transaction without any strobe.

Structure
REQ-031 State encodings and the timeout counter width SHALL live in the shared defines.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 Add instruction, zero-wait acks -> pc_en on cycle 4 only, rf_we=1, inst=inst_in.
REQ-034 Store with dmem_ack after 3 cycles -> dmem_we=1 for 4 cycles, rf_we=0, pc_en on cycle 8.
REQ-035 imem_ack withheld, MEM_TIMEOUT=15 -> bus_excp and pc_en on the 16th FETCH cycle, then new imem_req.
REQ-036 imem_ack coincident with timeout -> no bus_excp, state DECODE.
REQ-037 halt=1 in WB -> state=5, all strobes held 0 for 20 cycles; reset -> FETCH.
REQ-038 Reset asserted in MEM -> outputs 0 immediately, no rf_we or pc_en.
